// File: rtl/ram_burst_reader_if.sv
// ram_burst_reader_if
// Groups the burst-reader signals: the burst command/status handshake,
// the synchronous-read RAM port and the valid/ready output stream.
// Ports (signals):
//   start, base_addr, len   burst request and its parameters
//   busy, done_tick         burst status
//   ram_addr, ram_we        RAM address / write enable (reader never writes)
//   ram_dout                RAM read data, valid the cycle after the address edge
//   m_data, m_valid         output stream word and its valid
//   m_ready                 output stream sink ready
// Modports:
//   slave  - the reader's view
//   master - the environment's view (requester, RAM and stream sink)
interface ram_burst_reader_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   len;
    logic                  busy;
    logic                  done_tick;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport slave (
        input  start, base_addr, len, ram_dout, m_ready,
        output busy, done_tick, ram_addr, ram_we, m_data, m_valid
    );

    modport master (
        output start, base_addr, len, ram_dout, m_ready,
        input  busy, done_tick, ram_addr, ram_we, m_data, m_valid
    );
endinterface

// File: rtl/ram_burst_reader.sv
// ram_burst_reader
// Reads a burst of len words starting at base_addr from a single-port,
// synchronous-read RAM and streams them out over a valid/ready port.
// A two-entry FIFO absorbs the one-cycle RAM latency so that the stream
// runs at one word per cycle while the sink is ready.
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous active-high reset
//   bus    ram_burst_reader_if.slave (command, RAM port, output stream)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; len=0 requests answer with done_tick only
// RUN   | reads still to be issued
// DRAIN | all reads issued; waiting for the last word to be taken
module ram_burst_reader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    ram_burst_reader_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH:0]   remain;
    logic                  in_flight;

    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;

    logic                  done_r;
    logic                  done_next;

    logic                  pop;
    logic                  push;
    logic                  load;
    logic                  issue;
    logic                  last_pop;
    logic [2:0]            pending;

    assign pop  = (count != 2'd0) && bus.m_ready;
    assign push = in_flight;

    // Words that will occupy the FIFO once the in-flight read lands and
    // the current pop (if any) leaves. Issuing only while this is below
    // two is what keeps the FIFO from overflowing.
    assign pending = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};
    assign issue   = (state == RUN) && (pending < 3'd2);

    assign load     = (state == IDLE) && bus.start && (bus.len != '0);
    assign last_pop = (state == DRAIN) && pop && (count == 2'd1) && !in_flight;

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (issue && (remain == (ADDR_WIDTH+1)'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            done_r <= 1'b0;
        end else begin
            state  <= state_next;
            done_r <= done_next;
        end
    end

    // Address counter wraps naturally at 2**ADDR_WIDTH; remain is a
    // down-counter whose terminal count (1 on an issue) ends RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_cnt  <= '0;
            remain    <= '0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= issue;
            if (load) begin
                addr_cnt <= bus.base_addr;
                remain   <= bus.len;
            end else if (issue) begin
                addr_cnt <= addr_cnt + 1'b1;
                remain   <= remain - 1'b1;
            end
        end
    end

    // Read data arrives the cycle after issue, so in_flight doubles as the
    // FIFO write strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bus.ram_dout;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done_tick = done_r;
    assign bus.ram_addr  = addr_cnt;
    assign bus.ram_we    = 1'b0;
    assign bus.m_valid   = (count != 2'd0);
    assign bus.m_data    = fifo_mem[rd_ptr];

    fifo_no_overflow: assert property (
        @(posedge clk) disable iff (reset) !(push && !pop && (count == 2'd2))
    );

endmodule
